mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_if.sv | 40 ++++
 rtl/mem_arb_tagq.sv | 29 ++
 rtl/mem_arb.sv | 127 ++++++++++++
 tb/tb_mem_arb.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port ids, the read-return tag
// and the upper bound on memory read latency.
package mem_arb_pkg;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  localparam int RD_LAT_MAX = 8;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: two requester ports, the memory command/return
// channel and the orphan-return flag. slave = arbiter side, master = the
// requesters and memory that surround it.
interface mem_arb_if #(
  parameter int MEM_AW = 12,
  parameter int MEM_DW = 32
);

  logic              p0_req,       p1_req;
  logic              p0_write,     p1_write;
  logic [MEM_AW-1:0] p0_addr,      p1_addr;
  logic [MEM_DW-1:0] p0_wdata,     p1_wdata;
  logic              p0_gnt,       p1_gnt;
  logic [MEM_DW-1:0] p0_rdata,     p1_rdata;
  logic              p0_rdata_vld, p1_rdata_vld;

  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic [MEM_DW-1:0] mem_rdata;
  logic              mem_rdata_vld;

  logic              err_orphan;

  modport slave (
    input  p0_req, p1_req, p0_write, p1_write, p0_addr, p1_addr,
           p0_wdata, p1_wdata, mem_rdata, mem_rdata_vld,
    output p0_gnt, p1_gnt, p0_rdata, p1_rdata, p0_rdata_vld, p1_rdata_vld,
           mem_req, mem_write, mem_addr, mem_wdata, err_orphan
  );

  modport master (
    output p0_req, p1_req, p0_write, p1_write, p0_addr, p1_addr,
           p0_wdata, p1_wdata, mem_rdata, mem_rdata_vld,
    input  p0_gnt, p1_gnt, p0_rdata, p1_rdata, p0_rdata_vld, p1_rdata_vld,
           mem_req, mem_write, mem_addr, mem_wdata, err_orphan
  );

endinterface

// File: rtl/mem_arb_tagq.sv
// Read-return tag pipeline: one tag enters per cycle alongside the issued
// memory command and emerges RD_LAT cycles later, aligned with the memory's
// read return. RD_LAT must lie in 1..RD_LAT_MAX.
module mem_arb_tagq
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_pipe [RD_LAT];

  // shift tags one stage per cycle; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/mem_arb.sv
// Two-port round-robin memory arbiter with registered command and tagged
// read-return routing. Optional grant statistics when MEM_ARB_STATS_EN is
// defined (adds p0_gnt_cnt / p1_gnt_cnt saturating counters).
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int MEM_DW = 32,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_arb_if.slave    bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] p0_gnt_cnt,
  output logic [15:0] p1_gnt_cnt
`endif
);

  localparam logic [3:0] SUP_INIT = 4'(RD_LAT);

  logic              w_gnt0, w_gnt1;
  port_e             r_ptr, r_port;
  logic              r_mem_req, r_mem_write;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [MEM_DW-1:0] r_mem_wdata;
  logic              r_err;
  logic [3:0]        r_sup_cnt;
  tag_t              w_tag_in, w_tag_out;

  // a port wins if it is the only requester or the pointer favours it
  assign w_gnt0 = rst_n & bus.p0_req & (~bus.p1_req | (r_ptr == PORT0));
  assign w_gnt1 = rst_n & bus.p1_req & (~bus.p0_req | (r_ptr == PORT1));
  assign bus.p0_gnt = w_gnt0;
  assign bus.p1_gnt = w_gnt1;

  // round-robin pointer flips to the other port after every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr <= PORT0;
    else if (w_gnt0) r_ptr <= PORT1;
    else if (w_gnt1) r_ptr <= PORT0;
  end

  // register the granted command for one cycle on the memory bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_port      <= PORT0;
    end else begin
      r_mem_req <= w_gnt0 | w_gnt1;
      if (w_gnt0) begin
        r_mem_write <= bus.p0_write;
        r_mem_addr  <= bus.p0_addr;
        r_mem_wdata <= bus.p0_wdata;
        r_port      <= PORT0;
      end else if (w_gnt1) begin
        r_mem_write <= bus.p1_write;
        r_mem_addr  <= bus.p1_addr;
        r_mem_wdata <= bus.p1_wdata;
        r_port      <= PORT1;
      end else begin
        r_mem_write <= 1'b0;
      end
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  // tag travels with the issued command; only reads expect a return
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = r_mem_req & ~r_mem_write;
    w_tag_in.port  = r_port;
  end

  mem_arb_tagq #(.RD_LAT(RD_LAT)) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign bus.p0_rdata     = bus.mem_rdata;
  assign bus.p1_rdata     = bus.mem_rdata;
  assign bus.p0_rdata_vld = bus.mem_rdata_vld & w_tag_out.valid & (w_tag_out.port == PORT0);
  assign bus.p1_rdata_vld = bus.mem_rdata_vld & w_tag_out.valid & (w_tag_out.port == PORT1);

  // sticky orphan flag; returns from before reset are ignored for RD_LAT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_sup_cnt <= SUP_INIT;
    end else if (r_sup_cnt != 4'd0) begin
      r_sup_cnt <= r_sup_cnt - 4'd1;
    end else if (bus.mem_rdata_vld != w_tag_out.valid) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_orphan = r_err;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_cnt0, r_cnt1;

  // per-port grant counters that stop at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_gnt0 && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_gnt1 && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign p0_gnt_cnt = r_cnt0;
  assign p1_gnt_cnt = r_cnt1;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a small behavioural memory (fixed read
// latency, unwritten locations read back their own address).
module tb_mem_arb;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_arb_if #(.MEM_AW(AW), .MEM_DW(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  mem_arb #(.MEM_AW(AW), .MEM_DW(DW), .RD_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .p0_gnt_cnt (cnt0),
    .p1_gnt_cnt (cnt1)
`endif
  );

  // memory model: not reset, so stale returns can outlive a reset pulse
  logic [DW-1:0]        mem    [1<<AW];
  logic [(1<<AW)-1:0]   wr_vld = '0;
  logic [LAT-1:0]       rd_v   = '0;
  logic [DW-1:0]        rd_d   [LAT];
  logic                 force_vld = 1'b0;

  always @(posedge clk) begin
    rd_v[0] <= bus.mem_req & ~bus.mem_write;
    rd_d[0] <= wr_vld[bus.mem_addr] ? mem[bus.mem_addr] : DW'(bus.mem_addr);
    for (int i = 1; i < LAT; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_d[i] <= rd_d[i-1];
    end
    if (bus.mem_req && bus.mem_write) begin
      mem[bus.mem_addr]    <= bus.mem_wdata;
      wr_vld[bus.mem_addr] <= 1'b1;
    end
  end

  assign bus.mem_rdata     = rd_d[LAT-1];
  assign bus.mem_rdata_vld = rd_v[LAT-1] | force_vld;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cyc();
    rst_n = 1'b0;
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] rr_addr(input int j);
    return (j % 2 == 0) ? AW'(12'h100 + j) : AW'(12'h200 + j);
  endfunction

  initial begin
    bus.p0_req = 1'b0;  bus.p1_req = 1'b0;
    bus.p0_write = 1'b0; bus.p1_write = 1'b0;
    bus.p0_addr = '0;   bus.p1_addr = '0;
    bus.p0_wdata = '0;  bus.p1_wdata = '0;

    // in reset: quiet bus and no grant even with a request present
    #3;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_err", bus.err_orphan, 0);
    check("rst_p0_vld", bus.p0_rdata_vld, 0);
    bus.p0_req = 1'b1;
    #1;
    check("rst_no_gnt", bus.p0_gnt, 0);
    bus.p0_req = 1'b0;
    next_cyc();
    next_cyc();
    rst_n = 1'b1;

    // single p0 read of 0x010
    next_cyc();
    bus.p0_req = 1'b1; bus.p0_write = 1'b0; bus.p0_addr = 12'h010;
    #2;
    check("rd_p0_gnt", bus.p0_gnt, 1);
    check("rd_p1_gnt", bus.p1_gnt, 0);
    next_cyc();
    bus.p0_req = 1'b0;
    #2;
    check("rd_mem_req", bus.mem_req, 1);
    check("rd_mem_addr", bus.mem_addr, 12'h010);
    check("rd_mem_write", bus.mem_write, 0);
    next_cyc(); #2;
    check("rd_vld_early", bus.p0_rdata_vld, 0);
    next_cyc(); #2;
    check("rd_p0_vld", bus.p0_rdata_vld, 1);
    check("rd_p0_data", bus.p0_rdata, 32'h0000_0010);
    check("rd_p1_vld", bus.p1_rdata_vld, 0);
    next_cyc(); #2;
    check("rd_vld_after", bus.p0_rdata_vld, 0);
    check("rd_err", bus.err_orphan, 0);

    // both ports request for six cycles: alternating grants, back-to-back
    do_reset();
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      bus.p0_req = (i < 6); bus.p1_req = (i < 6);
      bus.p0_write = 1'b0;  bus.p1_write = 1'b0;
      bus.p0_addr = AW'(12'h100 + (i & ~1));
      bus.p1_addr = AW'(12'h200 + (i | 1));
      #2;
      check($sformatf("rr_gnt0_c%0d", i), bus.p0_gnt, (i < 6) && (i % 2 == 0));
      check($sformatf("rr_gnt1_c%0d", i), bus.p1_gnt, (i < 6) && (i % 2 == 1));
      check($sformatf("rr_mreq_c%0d", i), bus.mem_req, (i >= 1) && (i <= 6));
      if (i >= 1 && i <= 6)
        check($sformatf("rr_maddr_c%0d", i), bus.mem_addr, rr_addr(i - 1));
      check($sformatf("rr_v0_c%0d", i), bus.p0_rdata_vld,
            (i >= 3) && (i <= 8) && ((i - 3) % 2 == 0));
      check($sformatf("rr_v1_c%0d", i), bus.p1_rdata_vld,
            (i >= 3) && (i <= 8) && ((i - 3) % 2 == 1));
      if (i >= 3 && i <= 8)
        check($sformatf("rr_data_c%0d", i), bus.p0_rdata, DW'(rr_addr(i - 3)));
    end

    // p1 writes, p0 reads the same address next cycle; idle-port fields are junk
    next_cyc();
    bus.p1_req = 1'b1; bus.p1_write = 1'b1; bus.p1_addr = 12'h020; bus.p1_wdata = 32'hDEAD_BEEF;
    bus.p0_req = 1'b0; bus.p0_write = 1'b1; bus.p0_addr = 12'hFFF; bus.p0_wdata = 32'h1234_5678;
    #2;
    check("wr_p1_gnt", bus.p1_gnt, 1);
    check("wr_p0_gnt", bus.p0_gnt, 0);
    next_cyc();
    bus.p1_req = 1'b0; bus.p1_addr = 12'hABC;
    bus.p0_req = 1'b1; bus.p0_write = 1'b0; bus.p0_addr = 12'h020;
    #2;
    check("wr_p0_gnt2", bus.p0_gnt, 1);
    check("wr_p1_gnt2", bus.p1_gnt, 0);
    check("wr_mem_write", bus.mem_write, 1);
    check("wr_mem_addr", bus.mem_addr, 12'h020);
    check("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    next_cyc();
    bus.p0_req = 1'b0;
    #2;
    check("wr_rd_mreq", bus.mem_req, 1);
    check("wr_rd_mwrite", bus.mem_write, 0);
    check("wr_rd_maddr", bus.mem_addr, 12'h020);
    next_cyc(); #2;
    check("wr_no_ret_p0", bus.p0_rdata_vld, 0);
    check("wr_no_ret_p1", bus.p1_rdata_vld, 0);
    next_cyc(); #2;
    check("wr_rd_vld", bus.p0_rdata_vld, 1);
    check("wr_rd_data", bus.p0_rdata, 32'hDEAD_BEEF);

    // unsolicited return sets the sticky orphan flag
    next_cyc();
    force_vld = 1'b1;
    #2;
    check("orph_err_pre", bus.err_orphan, 0);
    check("orph_p0_vld", bus.p0_rdata_vld, 0);
    check("orph_p1_vld", bus.p1_rdata_vld, 0);
    next_cyc();
    force_vld = 1'b0;
    #2;
    check("orph_err_set", bus.err_orphan, 1);
    next_cyc(); next_cyc(); next_cyc(); #2;
    check("orph_err_hold", bus.err_orphan, 1);
    next_cyc();
    rst_n = 1'b0;
    #2;
    check("orph_err_clr", bus.err_orphan, 0);
    next_cyc();
    rst_n = 1'b1;

    // reset with two reads in flight
    next_cyc();
    bus.p0_req = 1'b1; bus.p0_write = 1'b0; bus.p0_addr = 12'h030;
    #2;
    check("ir_p0_gnt", bus.p0_gnt, 1);
    next_cyc();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b1; bus.p1_write = 1'b0; bus.p1_addr = 12'h040;
    #2;
    check("ir_p1_gnt", bus.p1_gnt, 1);
    next_cyc();
    bus.p1_req = 1'b0; bus.p0_req = 1'b1;
    rst_n = 1'b0;
    #2;
    check("ir_mreq", bus.mem_req, 0);
    check("ir_maddr", bus.mem_addr, 0);
    check("ir_mwrite", bus.mem_write, 0);
    check("ir_mwdata", bus.mem_wdata, 0);
    check("ir_no_gnt", bus.p0_gnt, 0);
    check("ir_err", bus.err_orphan, 0);
    next_cyc();
    rst_n = 1'b1; bus.p0_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      check($sformatf("ir_v0_c%0d", k), bus.p0_rdata_vld, 0);
      check($sformatf("ir_v1_c%0d", k), bus.p1_rdata_vld, 0);
      check($sformatf("ir_err_c%0d", k), bus.err_orphan, 0);
      next_cyc();
    end

`ifdef MEM_ARB_STATS_EN
    do_reset();
    #2;
    check("st_cnt0_rst", cnt0, 0);
    check("st_cnt1_rst", cnt1, 0);
    bus.p0_req = 1'b1; bus.p0_write = 1'b0; bus.p0_addr = 12'h000;
    repeat (70000) @(posedge clk);
    #1;
    bus.p0_req = 1'b0;
    #2;
    check("st_cnt0_sat", cnt0, 16'hFFFF);
    check("st_cnt1_zero", cnt1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
